// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the instruction cache.
// Widths are derived from LINES/WORDS so every file agrees on the address split.
package icache_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_FILL   = 2'd1;
  localparam state_t S_COMMIT = 2'd2;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int words);
    return 62 - off_w(words) - idx_w(lines);
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid bits and tags for the direct-mapped icache.
// Lookup is combinational; set-on-commit and flush-all land on the next edge.
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int LINES = 64,
  parameter int TAG_W = 56,
  localparam int IW = idx_w(LINES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IW-1:0]    rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             match,
  input  logic             set_en,
  input  logic [IW-1:0]    set_idx,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             flush_all
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (set_en) begin
      valid_q[set_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (set_en) begin
      tag_q[set_idx] <= set_tag;
    end
  end

  assign match = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

endmodule

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped icache with word-by-word refill over a req/valid handshake.
// Define ICACHE_STATS_EN to add hit_count/miss_count outputs.
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter int LINES = 64,
  parameter int WORDS = 4,
  parameter int METAL = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] addr,
  input  logic        read_en,
  input  logic        flush,
  output logic [31:0] data,
  output logic        stall,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OW = off_w(WORDS);
  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(LINES, WORDS);

  logic [OW-1:0] a_off;
  logic [IW-1:0] a_idx;
  logic [TW-1:0] a_tag;

  assign a_off = addr[OW+1:2];
  assign a_idx = addr[OW+2+:IW];
  assign a_tag = addr[63-:TW];

  state_t        state;
  logic [OW-1:0] cnt;
  logic [IW-1:0] lat_idx;
  logic [TW-1:0] lat_tag;
  logic          pend_flush;

  logic [31:0] data_q [LINES*WORDS];

  logic match;
  logic idle;
  logic hit;
  logic miss;
  logic last_word;
  logic set_en;

  assign idle      = (state == S_IDLE);
  assign hit       = idle && read_en && match;
  assign miss      = idle && read_en && !match;
  assign last_word = (cnt == OW'(WORDS - 1));
  // A flush seen anywhere during the fill, including COMMIT itself, kills the commit.
  assign set_en    = (state == S_COMMIT) && !pend_flush && !flush;

  icache_tag_array #(
    .LINES (LINES),
    .TAG_W (TW)
  ) u_tags (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (a_idx),
    .rd_tag    (a_tag),
    .match     (match),
    .set_en    (set_en),
    .set_idx   (lat_idx),
    .set_tag   (lat_tag),
    .flush_all (flush)
  );

  assign data     = data_q[{a_idx, a_off}];
  assign stall    = !idle || (read_en && !match);
  assign mem_req  = (state == S_FILL);
  assign mem_addr = mem_req ? {lat_tag, lat_idx, cnt, 2'b00} : 64'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_idx    <= '0;
      lat_tag    <= '0;
      pend_flush <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (miss) begin
            state   <= S_FILL;
            lat_idx <= a_idx;
            lat_tag <= a_tag;
            cnt     <= '0;
          end
        end
        S_FILL: begin
          if (mem_valid) begin
            cnt <= cnt + 1'b1;
            if (last_word) state <= S_COMMIT;
          end
        end
        S_COMMIT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
      if (state == S_COMMIT) begin
        pend_flush <= 1'b0;
      end else if (flush && state == S_FILL) begin
        pend_flush <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_req && mem_valid) begin
      data_q[{lat_idx, cnt}] <= mem_data;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)  hit_count  <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

  // Byte offset is irrelevant to word fetch; both instances reset identically.
  logic unused_ok;
  assign unused_ok = ^{addr[1:0], (METAL != 0)};

endmodule
